ram_word_ctrl: RTL

Word-access controller that sits directly upstream of the byte-wide `ram` block. Accepts 16-bit (or single-byte) read/write requests over a valid/ready interface and sequences them into byte accesses on the RAM's addr/data/cs/we/oe port. Stores words little-endian: low byte at A, high byte at A+1. Returns read data and write completion on a one-cycle response strobe.

---
 rtl/ram_word_ctrl_if.sv | 25 ++
 rtl/ram_word_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/ram_word_ctrl_if.sv
// Request/response bundle between a word-access client and ram_word_ctrl.
// The client drives requests as master; the controller answers as slave.
interface ram_word_ctrl_if #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 8
);
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_we;
   logic                      req_byte;
   logic [ADDR_WIDTH-1:0]     req_addr;
   logic [2*DATA_WIDTH-1:0]   req_wdata;
   logic                      rsp_valid;
   logic [2*DATA_WIDTH-1:0]   rsp_rdata;

   modport master (
      output req_valid, req_we, req_byte, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_byte, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/ram_word_ctrl.sv
// Sequences 16-bit or single-byte requests into little-endian byte accesses
// on a byte-wide RAM, returning a one-cycle completion strobe.
module ram_word_ctrl #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   ram_word_ctrl_if.slave        bus,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic                  mem_oe
);

   localparam int WordWidth = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_e;

   state_e                 state_q, state_d;
   logic                   we_q;
   logic                   byte_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [DATA_WIDTH-1:0]  wdataHi_q;
   logic [DATA_WIDTH-1:0]  rdataLo_q;
   logic [WordWidth-1:0]   rspRdata_q;
   logic [ADDR_WIDTH-1:0]  memAddr_q;
   logic [DATA_WIDTH-1:0]  memWdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.req_valid) state_d = LO;
         LO:      state_d = byte_q ? RESP : HI;
         HI:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes depend only on state and the latched direction, so they never glitch with req_*.
   always_comb begin
      bus.req_ready = (state_q == IDLE);
      bus.rsp_valid = (state_q == RESP);
      mem_cs        = (state_q == LO) || (state_q == HI);
      mem_we        = mem_cs && we_q;
      mem_oe        = mem_cs && !we_q;
   end

   // The RAM address/data registers are loaded one edge ahead of each byte beat
   // so they hold their last value through IDLE and RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q       <= 1'b0;
         byte_q     <= 1'b0;
         addr_q     <= '0;
         wdataHi_q  <= '0;
         rdataLo_q  <= '0;
         rspRdata_q <= '0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q       <= bus.req_we;
                  byte_q     <= bus.req_byte;
                  addr_q     <= bus.req_addr;
                  wdataHi_q  <= bus.req_wdata[WordWidth-1:DATA_WIDTH];
                  memAddr_q  <= bus.req_addr;
                  memWdata_q <= bus.req_wdata[DATA_WIDTH-1:0];
               end
            end
            LO: begin
               if (!we_q) begin
                  if (byte_q) begin
                     rspRdata_q <= {{DATA_WIDTH{1'b0}}, mem_rdata};
                  end else begin
                     rdataLo_q <= mem_rdata;
                  end
               end
               if (!byte_q) begin
                  memAddr_q  <= addr_q + ADDR_WIDTH'(1);
                  memWdata_q <= wdataHi_q;
               end
            end
            HI: begin
               if (!we_q) begin
                  rspRdata_q <= {mem_rdata, rdataLo_q};
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rsp_rdata = rspRdata_q;
   assign mem_addr      = memAddr_q;
   assign mem_wdata     = memWdata_q;

endmodule
